window_conv_33: RTL and testbench



---
 rtl/window_conv_33.sv | 123 ++++++++++++
 tb/tb_window_conv_33.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/window_conv_33.sv
// window_conv_33: builds zero-padded 3x3 ternary windows from the column stream
// and sums window*kernel over all channels into one signed value per pixel.
module window_conv_33 #(
    parameter int SIZE    = 28,
    parameter int CHANNEL = 128,
    parameter int WIDTH_O = 12
) (
    input  logic                                     i_sclk,
    input  logic                                     i_rst_n,
    input  logic                                     i_vsync,
    input  logic                                     i_hsync,
    input  logic                                     i_reuse,
    input  logic                                     i_valid,
    input  logic [5:0]                               i_tdata,
    input  logic                                     i_wen,
    input  logic [(CHANNEL > 1 ? $clog2(CHANNEL) : 1)-1:0] i_waddr,
    input  logic [17:0]                              i_wdata,
    output logic                                     o_vsync,
    output logic                                     o_hsync,
    output logic                                     o_reuse,
    output logic                                     o_valid,
    output logic [WIDTH_O-1:0]                       o_tdata,
    output logic                                     o_err
);
    localparam int CW = CHANNEL > 1 ? $clog2(CHANNEL) : 1;
    localparam int XW = SIZE > 1 ? $clog2(SIZE) : 1;
    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;
    state_t st, nxt;
    logic [CW-1:0] ch;
    logic [XW-1:0] col;
    logic beat, ch_last, col_last, fl;
    logic [5:0] line1 [CHANNEL];
    logic [5:0] line2 [CHANNEL];
    logic [17:0] kern [CHANNEL];
    logic v1, f1, l1, p1, r1, v2, f2, l2, p2, r2, rr, o_last;
    logic [5:0] lc1, cc1, rc1;
    logic [17:0] k1, wcol;
    logic signed [4:0] sum, s2;
    logic [WIDTH_O-1:0] acc, acc_nxt;
    logic [1:0] vs_d;
    logic unused;
    assign unused = i_hsync;
    function automatic logic signed [4:0] tmul(input logic [1:0] a, input logic [1:0] b);
        return (a[0] && b[0]) ? ((a[1] ^ b[1]) ? -5'sd1 : 5'sd1) : 5'sd0;
    endfunction
    always_comb begin
        fl = st == FLUSH;
        beat = i_valid && !i_vsync && !fl;
        ch_last = ch == CW'(CHANNEL - 1);
        col_last = col == XW'(SIZE - 1);
        nxt = st;
        if (i_vsync) nxt = IDLE;
        else if (fl) nxt = ch_last ? IDLE : FLUSH;
        else if (beat) nxt = (ch_last && col_last) ? FLUSH : (ch_last && col == '0) ? RUN : (st == IDLE) ? FILL : st;
    end
    always_ff @(posedge i_sclk or negedge i_rst_n) begin
        if (!i_rst_n) st <= IDLE;
        else st <= nxt;
    end
    always_ff @(posedge i_sclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ch <= '0;
            col <= '0;
        end else if (i_vsync) begin
            ch <= '0;
            col <= '0;
        end else if (beat || fl) begin
            ch <= ch_last ? '0 : ch + CW'(1);
            if (beat && ch_last) col <= col_last ? '0 : col + XW'(1);
        end
    end
    // line1 holds column x-1 and line2 column x-2 while column x streams in
    always_ff @(posedge i_sclk) begin
        if (i_wen) kern[i_waddr] <= i_wdata;
        if (beat) begin
            line1[ch] <= i_tdata;
            line2[ch] <= line1[ch];
        end
    end
    always_comb begin
        wcol = {rc1, cc1, lc1};
        sum = '0;
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < 3; k++)
                sum = sum + tmul(wcol[6*k+2*r +: 2], k1[2*(3*r+k) +: 2]);
        acc_nxt = (f2 ? '0 : acc) + {{(WIDTH_O-5){s2[4]}}, s2};
    end
    always_ff @(posedge i_sclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            {v1, f1, l1, p1, r1, v2, f2, l2, p2, r2, rr, o_last} <= '0;
            {lc1, cc1, rc1, k1, s2, acc, vs_d} <= '0;
            {o_vsync, o_hsync, o_reuse, o_valid, o_tdata, o_err} <= '0;
        end else begin
            v1 <= !i_vsync && (fl || (beat && col != '0));
            f1 <= ch == '0;
            l1 <= ch_last;
            p1 <= fl;
            r1 <= i_reuse;
            lc1 <= (fl ? (SIZE == 1) : (col == XW'(1))) ? '0 : line2[ch];
            cc1 <= line1[ch];
            rc1 <= fl ? '0 : i_tdata;
            k1 <= kern[ch];
            v2 <= v1 && !i_vsync;
            {f2, l2, p2, r2, s2} <= {f1, l1, p1, r1, sum};
            vs_d <= {vs_d[0], i_vsync};
            o_vsync <= vs_d[1];
            o_err <= i_valid && !i_vsync && fl;
            o_valid <= v2 && l2 && !i_vsync;
            if (i_vsync) acc <= '0;
            else if (v2) acc <= acc_nxt;
            if (v2 && f2) rr <= r2;
            if (v2 && l2 && !i_vsync) begin
                o_tdata <= acc_nxt;
                o_reuse <= f2 ? r2 : rr;
                o_hsync <= 1'b1;
                o_last <= p2;
            end else if (o_last || i_vsync) begin
                o_hsync <= 1'b0;
                o_last <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_window_conv_33.sv
// tb_window_conv_33: random rows checked against a direct zero-padded 3x3
// ternary convolution computed from image/kernel arrays.
module tb_window_conv_33;
    localparam int SIZE = 4, CHANNEL = 4, WIDTH_O = 12;
    logic i_sclk = 0, i_rst_n = 0, i_vsync = 0, i_hsync = 0, i_reuse = 0, i_valid = 0, i_wen = 0;
    logic [5:0] i_tdata = 0;
    logic [1:0] i_waddr = 0;
    logic [17:0] i_wdata = 0;
    logic o_vsync, o_hsync, o_reuse, o_valid, o_err;
    logic [WIDTH_O-1:0] o_tdata;

    window_conv_33 #(.SIZE(SIZE), .CHANNEL(CHANNEL), .WIDTH_O(WIDTH_O)) dut (
        .i_sclk(i_sclk), .i_rst_n(i_rst_n), .i_vsync(i_vsync), .i_hsync(i_hsync),
        .i_reuse(i_reuse), .i_valid(i_valid), .i_tdata(i_tdata), .i_wen(i_wen),
        .i_waddr(i_waddr), .i_wdata(i_wdata), .o_vsync(o_vsync), .o_hsync(o_hsync),
        .o_reuse(o_reuse), .o_valid(o_valid), .o_tdata(o_tdata), .o_err(o_err));

    always #5 i_sclk = ~i_sclk;

    int cyc = 0;
    always @(posedge i_sclk) cyc <= cyc + 1;

    int checks = 0, errors = 0, err_cnt = 0, vs_rise = -1, vc;
    logic ovs_d = 0;
    logic [WIDTH_O-1:0] out_q[$];
    int ocyc_q[$], trig_q[$];
    logic rq[$];
    logic [1:0] img [SIZE][CHANNEL][3];
    logic [1:0] kern [CHANNEL][9];

    always @(negedge i_sclk) begin
        if (o_valid) begin
            out_q.push_back(o_tdata);
            ocyc_q.push_back(cyc);
            rq.push_back(o_reuse);
            checks++;
            assert (o_hsync === 1'b1) else begin
                errors++;
                $error("FAIL hsync_at_valid observed=%b expected=1", o_hsync);
            end
        end
        if (o_err) err_cnt++;
        if (o_vsync && !ovs_d) vs_rise = cyc;
        ovs_d = o_vsync;
    end

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge i_sclk);
        #1;
    endtask

    function automatic int tv(input logic [1:0] c);
        return c == 2'b01 ? 1 : c == 2'b11 ? -1 : 0;
    endfunction

    function automatic int exp_pix(input int x);
        int s = 0;
        for (int c = 0; c < CHANNEL; c++)
            for (int r = 0; r < 3; r++)
                for (int k = 0; k < 3; k++)
                    if (x + k - 1 >= 0 && x + k - 1 < SIZE)
                        s += tv(img[x+k-1][c][r]) * tv(kern[c][3*r+k]);
        return s;
    endfunction

    task automatic fill_img(input bit ones);
        for (int x = 0; x < SIZE; x++)
            for (int c = 0; c < CHANNEL; c++)
                for (int r = 0; r < 3; r++)
                    img[x][c][r] = ones ? 2'b01 : 2'($urandom_range(0, 3));
    endtask

    task automatic wr_kern(input int c);
        logic [17:0] w;
        for (int t = 0; t < 9; t++) w[2*t +: 2] = kern[c][t];
        i_wen = 1; i_waddr = 2'(c); i_wdata = w;
        tick;
        i_wen = 0;
    endtask

    task automatic set_kern(input int c, input int mode);
        for (int t = 0; t < 9; t++)
            kern[c][t] = mode == 1 ? 2'b01 : mode == 2 ? 2'b11 : 2'($urandom_range(0, 3));
        wr_kern(c);
    endtask

    task automatic clear_q;
        out_q.delete(); ocyc_q.delete(); rq.delete(); trig_q.delete();
    endtask

    task automatic drive_row(input int gmax, input logic reuse, input int ncols, input bit inj);
        int last = 0;
        i_hsync = 1; i_reuse = reuse;
        for (int x = 0; x < ncols; x++)
            for (int c = 0; c < CHANNEL; c++) begin
                i_valid = 0;
                repeat ($urandom_range(0, gmax)) tick;
                i_valid = 1;
                i_tdata = {img[x][c][2], img[x][c][1], img[x][c][0]};
                if (c == CHANNEL - 1 && x >= 1) trig_q.push_back(cyc);
                last = cyc;
                tick;
            end
        i_valid = 0;
        if (ncols == SIZE) trig_q.push_back(last + CHANNEL);
        if (inj) begin
            i_valid = 1; i_tdata = 6'($urandom);
            tick;
            i_valid = 0;
        end
        i_hsync = 0;
    endtask

    task automatic check_row(input string tag, input logic reuse);
        int t = 0;
        while (out_q.size() < SIZE && t < 300) begin tick; t++; end
        chk({tag, "_count"}, out_q.size(), SIZE);
        for (int x = 0; x < SIZE; x++)
            if (x < out_q.size() && x < trig_q.size()) begin
                chk($sformatf("%s_pix%0d", tag, x), int'($signed(out_q[x])), exp_pix(x));
                chk($sformatf("%s_lat%0d", tag, x), ocyc_q[x] - trig_q[x], 3);
                chk($sformatf("%s_reuse%0d", tag, x), int'(rq[x]), int'(reuse));
            end
        repeat (5) tick;
        chk({tag, "_extra"}, out_q.size(), SIZE);
        chk({tag, "_hsync_low"}, int'(o_hsync), 0);
        clear_q();
    endtask

    initial begin
        repeat (3) tick;
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_tdata", int'(o_tdata), 0);
        chk("rst_hsync", int'(o_hsync), 0);
        chk("rst_vsync", int'(o_vsync), 0);
        chk("rst_err", int'(o_err), 0);
        chk("rst_reuse", int'(o_reuse), 0);
        i_rst_n = 1;
        tick;
        fill_img(1);
        for (int c = 0; c < CHANNEL; c++) set_kern(c, 1);
        drive_row(0, 0, SIZE, 0);
        check_row("ones", 0);
        set_kern(1, 2);
        drive_row(0, 1, SIZE, 0);
        check_row("neg_ch1", 1);
        set_kern(1, 1);
        drive_row(0, 0, SIZE, 0);
        check_row("rewrite", 0);
        for (int n = 0; n < 3; n++) begin
            logic rr;
            rr = 1'($urandom);
            fill_img(0);
            for (int c = 0; c < CHANNEL; c++) set_kern(c, 3);
            drive_row(3, rr, SIZE, 0);
            check_row($sformatf("rand%0d", n), rr);
        end
        fill_img(0);
        drive_row(1, 0, 3, 0);
        repeat (10) tick;
        chk("vs_pre_count", out_q.size(), 2);
        for (int x = 0; x < 2; x++)
            if (x < out_q.size()) chk($sformatf("vs_pre_pix%0d", x), int'($signed(out_q[x])), exp_pix(x));
        clear_q();
        vc = cyc;
        i_vsync = 1;
        tick;
        i_vsync = 0;
        repeat (30) tick;
        chk("vs_no_valid", out_q.size(), 0);
        chk("vs_delay", vs_rise - vc, 3);
        clear_q();
        fill_img(0);
        drive_row(2, 0, SIZE, 0);
        check_row("after_vs", 0);
        err_cnt = 0;
        fill_img(0);
        drive_row(2, 1, SIZE, 1);
        check_row("flush_err", 1);
        chk("err_pulses", err_cnt, 1);
        fill_img(0);
        drive_row(1, 0, SIZE, 0);
        check_row("post_err", 0);
        fill_img(0);
        drive_row(0, 1, 2, 0);
        repeat (2) tick;
        chk("pre_rst_valid", int'(o_valid), 1);
        #2 i_rst_n = 0;
        #1;
        chk("arst_valid", int'(o_valid), 0);
        chk("arst_tdata", int'(o_tdata), 0);
        chk("arst_hsync", int'(o_hsync), 0);
        chk("arst_reuse", int'(o_reuse), 0);
        #2 i_rst_n = 1;
        tick;
        clear_q();
        drive_row(1, 0, SIZE, 0);
        check_row("post_rst", 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
